// File: rtl/rs_pkg.sv
// Shared definitions for the RS encoder: field polynomial, generator tables and FSM states.
// Generator tables are built at elaboration as prod_{i<nsym} (x + alpha^i), monic term omitted.
package rs_pkg;

  localparam int RS_SYM_W    = 10;
  localparam int RS_NSYM_MAX = 30;
  localparam int NSYM_KP4    = 30;
  localparam int NSYM_KR4    = 14;

  localparam logic [RS_SYM_W:0] PRIM_POLY = 11'h409;

  typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

  typedef logic [RS_NSYM_MAX-1:0][RS_SYM_W-1:0] gtab_t;

  function automatic logic [RS_SYM_W-1:0] gf_mul(input logic [RS_SYM_W-1:0] a,
                                                 input logic [RS_SYM_W-1:0] b);
    logic [RS_SYM_W-1:0] acc;
    logic [RS_SYM_W-1:0] xs;
    acc = '0;
    xs  = a;
    for (int i = 0; i < RS_SYM_W; i++) begin
      if (b[i]) acc = acc ^ xs;
      xs = xs[RS_SYM_W-1] ? ((xs << 1) ^ PRIM_POLY[RS_SYM_W-1:0]) : (xs << 1);
    end
    return acc;
  endfunction

  function automatic gtab_t gen_poly(input int nsym);
    logic [RS_SYM_W-1:0] g [RS_NSYM_MAX+1];
    logic [RS_SYM_W-1:0] root;
    gtab_t t;
    for (int j = 0; j <= RS_NSYM_MAX; j++) g[j] = '0;
    g[0] = RS_SYM_W'(1);
    root = RS_SYM_W'(1);
    for (int i = 0; i < nsym; i++) begin
      for (int j = RS_NSYM_MAX; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, RS_SYM_W'(2));
    end
    for (int j = 0; j < RS_NSYM_MAX; j++) t[j] = (j < nsym) ? g[j] : '0;
    return t;
  endfunction

  localparam gtab_t G_KP4 = gen_poly(NSYM_KP4);
  localparam gtab_t G_KR4 = gen_poly(NSYM_KR4);

endpackage

// File: rtl/gf_mul_var.sv
// Variable-coefficient GF(2^SYM_W) multiplier: shift-and-add with reduction by POLY.
module gf_mul_var #(
  parameter int              SYM_W = 10,
  parameter logic [SYM_W:0]  POLY  = 11'h409
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic [SYM_W-1:0] p
);

  function automatic logic [SYM_W-1:0] mul(input logic [SYM_W-1:0] x,
                                           input logic [SYM_W-1:0] y);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] xs;
    acc = '0;
    xs  = x;
    for (int i = 0; i < SYM_W; i++) begin
      if (y[i]) acc = acc ^ xs;
      xs = xs[SYM_W-1] ? ((xs << 1) ^ POLY[SYM_W-1:0]) : (xs << 1);
    end
    return acc;
  endfunction

  assign p = mul(a, b);

endmodule

// File: rtl/rs_enc_flex.sv
// Dual-mode (KP4 / KR4) systematic RS encoder with valid/ready on both sides and shortened-code support.
//   state  | meaning
//   IDLE   | waiting for sop; non-sop symbols are swallowed
//   MSG    | message symbols pass straight through while the parity LFSR runs
//   PARITY | parity symbols shifted out from the top of the LFSR, input stalled
module rs_enc_flex import rs_pkg::*; #(
  parameter int SYM_W    = RS_SYM_W,
  parameter int K        = 514,
  parameter int NSYM_MAX = RS_NSYM_MAX,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [SYM_W-1:0] out_data,
  output logic             err_len
);

  localparam int                NSYM_W = $clog2(NSYM_MAX + 1);
  localparam logic [CNT_W-1:0]  K_C    = CNT_W'(K);
  localparam logic [NSYM_W-1:0] NS_KP4 = NSYM_W'(NSYM_KP4);
  localparam logic [NSYM_W-1:0] NS_KR4 = NSYM_W'(NSYM_KR4);

  state_t              state;
  logic                rdy_en;
  logic [CNT_W-1:0]    count, cnt_sat, cnt_next;
  logic [NSYM_W-1:0]   nsym_q, nsym_eff, par_cnt;
  logic [SYM_W-1:0]    sh     [NSYM_MAX];
  logic [SYM_W-1:0]    g_sel  [NSYM_MAX];
  logic [SYM_W-1:0]    prod   [NSYM_MAX];
  logic [SYM_W-1:0]    top_sym, fb;
  logic                msg_xfer, last, cnt_full;

  // In IDLE the sop symbol must already use the mode it arrives with.
  assign nsym_eff = (state == IDLE) ? (mode ? NS_KR4 : NS_KP4) : nsym_q;
  assign top_sym  = sh[nsym_q - 1'b1];
  assign fb       = (state == MSG) ? (in_data ^ top_sym) : in_data;

  always_comb begin
    for (int j = 0; j < NSYM_MAX; j++)
      g_sel[j] = (nsym_eff == NS_KR4) ? G_KR4[j] : G_KP4[j];
  end

  for (genvar j = 0; j < NSYM_MAX; j++) begin : g_mul
    gf_mul_var #(.SYM_W(SYM_W), .POLY(PRIM_POLY)) u_mul (
      .a(fb),
      .b(g_sel[j]),
      .p(prod[j])
    );
  end

  assign cnt_sat  = (count == K_C) ? count : count + 1'b1;
  assign cnt_next = (state == IDLE) ? CNT_W'(1) : cnt_sat;
  assign cnt_full = (cnt_next == K_C);
  assign last     = in_eop | cnt_full;
  assign msg_xfer = in_valid & in_ready & ((state == MSG) | in_sop);

  always_comb begin
    in_ready  = rdy_en & out_ready & (state != PARITY);
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = in_data;
    case (state)
      IDLE: begin
        out_valid = rdy_en & in_valid & in_sop;
        out_sop   = in_sop;
      end
      MSG:    out_valid = in_valid;
      PARITY: begin
        out_valid = 1'b1;
        out_data  = top_sym;
        out_eop   = (par_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy_en  <= 1'b0;
      count   <= '0;
      nsym_q  <= NS_KP4;
      par_cnt <= '0;
      err_len <= 1'b0;
      for (int j = 0; j < NSYM_MAX; j++) sh[j] <= '0;
    end else begin
      rdy_en  <= 1'b1;
      err_len <= msg_xfer & last & (in_eop ^ cnt_full);
      if (msg_xfer) begin
        sh[0] <= prod[0];
        for (int j = 1; j < NSYM_MAX; j++)
          sh[j] <= (NSYM_W'(j) < nsym_eff) ? (sh[j-1] ^ prod[j]) : '0;
        count <= cnt_next;
        if (state == IDLE) nsym_q <= nsym_eff;
        if (last) begin
          state   <= PARITY;
          par_cnt <= nsym_eff - 1'b1;
        end else begin
          state   <= MSG;
        end
      end else if (state == PARITY && out_ready) begin
        sh[0] <= '0;
        for (int j = 1; j < NSYM_MAX; j++)
          sh[j] <= (NSYM_W'(j) < nsym_q) ? sh[j-1] : '0;
        if (par_cnt == '0) begin
          state <= IDLE;
          count <= '0;
        end else begin
          par_cnt <= par_cnt - 1'b1;
          count   <= cnt_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_enc_flex.sv
// Self-checking bench for rs_enc_flex: table of packet scenarios checked against a polynomial-division model.
module tb_rs_enc_flex;

  localparam int KK = 514;

  logic       clk = 1'b0;
  logic       rst_n, mode, in_valid, in_ready, in_sop, in_eop;
  logic       out_valid, out_ready, out_sop, out_eop, err_len;
  logic [9:0] in_data, out_data;

  always #5 clk = ~clk;

  rs_enc_flex dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .err_len(err_len)
  );

  typedef struct {
    bit mode;
    int len;
    int pat;      // 0 zeros, 1 zeros then 0x001, 2 random
    bit eop;
    bit stall;
    bit toggle;
    bit extra;
    int exp_nout;
    int exp_err;
  } vec_t;

  vec_t tbl[8];
  int   n_chk = 0;
  int   n_err = 0;
  int   err_pulses = 0;
  int   exp_t[1024];
  int   log_t[1024];
  int   gp[2][31];
  int   msg_q[$], exp_q[$], got_q[$];
  bit   got_sop[$], got_eop[$];

  always @(negedge clk) if (rst_n && err_len) err_pulses++;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void build_field();
    int v = 1;
    for (int i = 0; i < 1023; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = v << 1;
      if ((v & 1024) != 0) v = v ^ 'h409;
    end
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 1023];
  endfunction

  function automatic void build_gen(input int m, input int nsym);
    int g[31];
    for (int j = 0; j < 31; j++) g[j] = 0;
    g[0] = 1;
    for (int i = 0; i < nsym; i++) begin
      for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], exp_t[i]);
      g[0] = gmul(g[0], exp_t[i]);
    end
    for (int j = 0; j < 31; j++) gp[m][j] = g[j];
  endfunction

  // Remainder of x^nsym * m(x) mod g(x) by long division over the full-length (zero-padded) message.
  task automatic build_expected(input int m, input int nsym);
    int r[$];
    int c;
    exp_q = {};
    for (int i = 0; i < KK - msg_q.size(); i++) r.push_back(0);
    foreach (msg_q[i]) r.push_back(msg_q[i]);
    for (int i = 0; i < nsym; i++) r.push_back(0);
    for (int i = 0; i < KK; i++) begin
      c = r[i];
      if (c != 0)
        for (int j = 0; j <= nsym; j++) r[i+j] = r[i+j] ^ gmul(c, gp[m][nsym-j]);
    end
    foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
    for (int i = KK; i < KK + nsym; i++) exp_q.push_back(r[i]);
  endtask

  task automatic run_entry(input int e);
    vec_t v;
    int   nsym, idx, cyc, stall_bad, extra_acc, err0, bad, first_bad;
    int   sop_cnt, sop_first, eop_cnt, eop_first, gbad;
    logic done, prev_stall, extra_on, accepted;
    logic [9:0] prev_data;
    v = tbl[e];
    nsym = v.mode ? 14 : 30;
    msg_q = {};
    for (int i = 0; i < v.len; i++) begin
      if (v.pat == 0) msg_q.push_back(0);
      else if (v.pat == 1) msg_q.push_back((i == v.len - 1) ? 1 : 0);
      else msg_q.push_back(int'($urandom_range(1023)));
    end
    build_expected(int'(v.mode), nsym);
    got_q = {}; got_sop = {}; got_eop = {};
    mode = v.mode;
    idx = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    stall_bad = 0; extra_acc = 0; extra_on = 1'b0;
    err0 = err_pulses;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    while (!done && cyc < 4000) begin
      if (!in_valid) begin
        if (idx < v.len) begin
          if (!(v.stall && $urandom_range(3) == 0)) begin
            in_valid = 1'b1;
            in_data  = 10'(msg_q[idx]);
            in_sop   = (idx == 0);
            in_eop   = v.eop && (idx == v.len - 1);
          end
        end else if (v.extra) begin
          in_valid = 1'b1; in_data = 10'h155; in_sop = 1'b0; in_eop = 1'b0; extra_on = 1'b1;
        end
      end
      out_ready = v.stall ? 1'($urandom_range(1)) : 1'b1;
      if (v.toggle && idx == v.len / 2) mode = ~v.mode;
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        got_sop.push_back(out_sop);
        got_eop.push_back(out_eop);
        if (out_eop) done = 1'b1;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        if (extra_on) extra_acc++;
        else idx++;
      end
      @(posedge clk); #1;
      if (accepted) begin in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; end
      cyc++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;

    chk($sformatf("e%0d_done", e), int'(done), 1);
    chk($sformatf("e%0d_nout", e), got_q.size(), v.exp_nout);
    bad = 0; first_bad = -1;
    foreach (got_q[i]) begin
      if (i >= exp_q.size() || got_q[i] != exp_q[i]) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL e%0d_data: %0d bad symbols, first at %0d got %h expected %h", e, bad, first_bad,
               got_q[first_bad], (first_bad < exp_q.size()) ? exp_q[first_bad] : -1);
    end
    sop_cnt = 0; sop_first = -1; eop_cnt = 0; eop_first = -1;
    foreach (got_sop[i]) begin
      if (got_sop[i]) begin if (sop_cnt == 0) sop_first = i; sop_cnt++; end
      if (got_eop[i]) begin if (eop_cnt == 0) eop_first = i; eop_cnt++; end
    end
    chk($sformatf("e%0d_sop_cnt", e), sop_cnt, 1);
    chk($sformatf("e%0d_sop_idx", e), sop_first, 0);
    chk($sformatf("e%0d_eop_cnt", e), eop_cnt, 1);
    chk($sformatf("e%0d_eop_idx", e), eop_first, v.exp_nout - 1);
    chk($sformatf("e%0d_err_len", e), err_pulses - err0, v.exp_err);
    chk($sformatf("e%0d_stall_stable", e), stall_bad, 0);
    if (v.extra) chk($sformatf("e%0d_extra_held", e), extra_acc, 0);
    if (v.pat == 1 && got_q.size() >= KK + 30) begin
      gbad = 0;
      for (int i = 0; i < 30; i++) if (got_q[KK+i] != gp[0][29-i]) gbad++;
      chk($sformatf("e%0d_gen_coeffs_bad", e), gbad, 0);
    end
  endtask

  task automatic reset_mid_parity();
    int idx, par, cyc;
    mode = 1'b0; out_ready = 1'b1;
    idx = 0; par = 0; cyc = 0;
    while (par < 10 && cyc < 2000) begin
      if (idx < KK) begin
        in_valid = 1'b1; in_data = 10'($urandom_range(1023));
        in_sop = (idx == 0); in_eop = (idx == KK - 1);
      end else begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      @(negedge clk);
      if (idx < KK) begin
        if (in_valid && in_ready) idx++;
      end else if (out_valid && out_ready) begin
        par++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_seq_par_reached", par, 10);
    chk("par10_out_valid", int'(out_valid), 1);
    chk("par10_out_eop", int'(out_eop), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_out_valid", int'(out_valid), 0);
    chk("after_rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    build_field();
    build_gen(0, 30);
    build_gen(1, 14);
    //          mode  len  pat eop   stall toggle extra nout err
    tbl[0] = '{1'b0, 514, 0, 1'b1, 1'b0, 1'b0, 1'b0, 544, 0};
    tbl[1] = '{1'b0, 514, 1, 1'b1, 1'b0, 1'b0, 1'b0, 544, 0};
    tbl[2] = '{1'b1, 514, 2, 1'b1, 1'b0, 1'b1, 1'b0, 528, 0};
    tbl[3] = '{1'b0, 514, 2, 1'b1, 1'b1, 1'b0, 1'b0, 544, 0};
    tbl[4] = '{1'b0, 400, 2, 1'b1, 1'b0, 1'b0, 1'b0, 430, 1};
    tbl[5] = '{1'b1, 514, 2, 1'b0, 1'b0, 1'b0, 1'b1, 528, 1};
    tbl[6] = '{1'b1,   1, 2, 1'b1, 1'b0, 1'b0, 1'b0,  15, 1};
    tbl[7] = '{1'b0, 514, 2, 1'b1, 1'b1, 1'b0, 1'b0, 544, 0};

    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
    in_data = 10'h3ff; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_len", int'(err_len), 0);
    in_valid = 1'b0; in_sop = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("pre_edge_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_data = 10'h02a;
    @(negedge clk);
    chk("drop_in_ready", int'(in_ready), 1);
    chk("drop_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    for (int e = 0; e < 7; e++) run_entry(e);
    reset_mid_parity();
    run_entry(7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
